switch_debouncer: RTL



---
 rtl/board_io_pkg.sv | 20 ++
 rtl/sync2.sv | 27 ++
 rtl/switch_debouncer.sv | 94 +++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared definitions for the board-input conditioning blocks: debouncer
// state encoding and the system clock rate used to size qualification windows.
package board_io_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Bit 1 is the debounced level and bit 0 is "qualifying", so both outputs
  // come straight off state flops.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } debounce_state_t;

  function automatic int unsigned cycles_for_ms(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous board input; both stages load
// RESET_VALUE while reset is asserted.
module sync2 #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_reg;
  logic s2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg <= RESET_VALUE;
      s2_reg <= RESET_VALUE;
    end else begin
      s1_reg <= d;
      s2_reg <= s1_reg;
    end
  end

  assign q = s2_reg;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces one raw switch/key: synchronises D, requires STABLE_CYCLES steady
// cycles before Q follows, and strobes Rise/Fall on the first cycle of each new level.
module switch_debouncer
  import board_io_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = cycles_for_ms(10),
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic D,
  output logic Q,
  output logic Rise,
  output logic Fall,
  output logic Busy
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam debounce_state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic             s2;
  debounce_state_t  state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;

  sync2 #(.RESET_VALUE(RESET_LEVEL)) u_sync (
    .clk (Clk),
    .rst (Reset),
    .d   (D),
    .q   (s2)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      STABLE_LO: if (s2) begin
        state_next = WAIT_HI;
        cnt_next   = '0;
      end
      WAIT_HI: begin
        if (!s2) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = STABLE_HI;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STABLE_HI: if (!s2) begin
        state_next = WAIT_LO;
        cnt_next   = '0;
      end
      WAIT_LO: begin
        if (s2) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = STABLE_LO;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  assign Q    = state_reg[1];
  assign Busy = state_reg[0];
  assign Rise = rise_reg;
  assign Fall = fall_reg;

endmodule
